// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Brings up SB_PLL40_CORE from the 48 MHz HFOSC domain and holds
//               the PLL-domain reset until LOCK has been stable for a settle
//               window; retries on timeout or loss, then faults.
//               Optional macro PLL_BYPASS_FALLBACK_EN: in FAULT, bypass the PLL
//               and release sys_rst onto the 48 MHz reference.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int SETTLE_CYCLES = 480,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk_48mhz,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_rst,
    output logic       locked_stable,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_HOLD  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       c_max_retries  = 2'(MAX_RETRIES);
`ifdef PLL_BYPASS_FALLBACK_EN
    localparam logic [CNT_W-1:0] c_rst_full     = CNT_W'(RESET_CYCLES);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             sync1_q, lock_s_q;
    logic             retry_path;

    logic             resetb_q, resetb_d;
    logic             sys_rst_q, sys_rst_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;

    // Raw LOCK is asynchronous to clk_48mhz.
    always_ff @(posedge clk_48mhz or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_48mhz or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            resetb_q  <= 1'b0;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            resetb_q  <= resetb_d;
            sys_rst_q <= sys_rst_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        retry_path = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RST_HOLD;
                    cnt_d   = '0;
                end
                ST_RST_HOLD: begin
                    if (cnt_q == c_rst_last) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as a lock.
                    if (lock_s_q) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == c_timeout_last) begin
                        retry_path = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s_q) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == c_settle_last) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        retry_path = 1'b1;
                    end
                end
                ST_FAULT: begin
`ifdef PLL_BYPASS_FALLBACK_EN
                    // Saturates at RESET_CYCLES; the terminal value releases sys_rst.
                    if (cnt_q != c_rst_full) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase

            if (retry_path) begin
                cnt_d = '0;
                if (retry_q == c_max_retries) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_RST_HOLD;
                    retry_d = retry_q + 2'd1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge.
    always_comb begin
        resetb_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) ||
                    (state_d == ST_RUN);
        sys_rst_d = (state_d != ST_RUN);
        locked_d  = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
`ifdef PLL_BYPASS_FALLBACK_EN
        if (state_d == ST_FAULT) begin
            resetb_d  = 1'b1;
            sys_rst_d = (cnt_d != c_rst_full);
        end
`endif
    end

`ifdef PLL_BYPASS_FALLBACK_EN
    logic bypass_q;

    always_ff @(posedge clk_48mhz or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= (state_d == ST_FAULT);
        end
    end

    assign pll_bypass = bypass_q;
`else
    assign pll_bypass = 1'b0;
`endif

    assign pll_resetb    = resetb_q;
    assign sys_rst       = sys_rst_q;
    assign locked_stable = locked_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign state_o       = state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the SB_PLL40_CORE from the 48 MHz HFOSC domain: drives RESETB/BYPASS and watches LOCK.
- Only releases the PLL-domain reset (sys_rst) after LOCK has been continuously stable for a settle window.
- Retries on lock timeout or lock loss, up to a retry limit, then enters a fault state.
- Sits between the HFOSC/PLL primitives and all logic clocked by the PLL output; replaces direct gating of outputs with raw PLL LOCK.

Parameters:
- RESET_CYCLES, 16: clk_48mhz cycles RESETB is held low per attempt (>=1).
- LOCK_TIMEOUT, 4800: cycles to wait for synchronised lock (100 us) before retrying.
- SETTLE_CYCLES, 480: consecutive synchronised-lock cycles required before release (10 us).
- MAX_RETRIES, 3: retries allowed before FAULT (0 means first failure faults).
- CNT_W, 16: width of the shared cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES).

Ports:
- clk_48mhz  in  1  HFOSC clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; high requests PLL bring-up, low forces shutdown.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk_48mhz.
- pll_resetb  out  1  to PLL RESETB, active-low.
- pll_bypass  out  1  to PLL BYPASS.
- sys_rst  out  1  active-high reset for the PLL-clock domain.
- locked_stable  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- retry_cnt  out  2  retries consumed in the current bring-up.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values: pll_resetb=0, pll_bypass=0, sys_rst=1, locked_stable=0, fault=0, retry_cnt=0, state=IDLE(0), counter=0.
- All outputs are registered.
- pll_lock passes through a 2-flop synchroniser to give lock_s. Lock edges reach the FSM with 2 cycles of latency.
- State encodings: IDLE=0, RST_HOLD=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5.
- IDLE:
  - pll_resetb=0, sys_rst=1.
  - When enable=1: go to RST_HOLD, counter=0.
- RST_HOLD:
  - pll_resetb=0 for exactly RESET_CYCLES cycles.
  - Then go to WAIT_LOCK with pll_resetb=1 and counter=0.
- WAIT_LOCK:
  - If lock_s=1: go to SETTLE, counter=0.
  - Else if counter==LOCK_TIMEOUT-1: take the retry path.
  - Else counter increments.
- SETTLE:
  - If lock_s=0: go back to WAIT_LOCK, counter=0. A glitch is not counted as a retry.
  - If lock_s=1 and counter==SETTLE_CYCLES-1: go to RUN.
- RUN:
  - On entry, in the same edge: sys_rst=0, locked_stable=1, retry_cnt=0.
  - If lock_s=0: next edge sys_rst=1 and locked_stable=0, then take the retry path.
- Retry path:
  - If retry_cnt==MAX_RETRIES: go to FAULT.
  - Else retry_cnt increments and the FSM goes to RST_HOLD with counter=0.
- FAULT:
  - fault=1, pll_resetb=0, sys_rst=1.
  - Left only via enable=0, which goes to IDLE (fault clears).
- enable=0 in any state goes to IDLE on the next edge. That edge also sets pll_resetb=0, sys_rst=1, locked_stable=0, counters=0 and retry_cnt=0. This has priority over all other transitions.
- Simultaneous events:
  - WAIT_LOCK: lock_s=1 on the timeout cycle means lock wins.
  - SETTLE: lock_s=0 on the final cycle means lock loss wins.
- The counter never wraps, because every terminal compare resets it.
- An asynchronous rst mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: PLL_BYPASS_FALLBACK_EN.
- With the macro defined, FAULT instead does the following:
  - pll_bypass=1 and pll_resetb=1.
  - After RESET_CYCLES cycles, sys_rst=0, so downstream runs on the 48 MHz reference passed through the PLL.
  - fault stays 1 and locked_stable stays 0.
  - enable=0 clears pll_bypass and returns to IDLE.
- Without the macro: pll_bypass is tied 0 and FAULT holds sys_rst=1.

Test Plan:
All scenarios use bench parameters RESET_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
1. Normal bring-up: rst released, enable=1; pll_lock rises 10 cycles after pll_resetb goes high -> pll_resetb low exactly 4 cycles; sys_rst falls 2+8 cycles after the pll_lock edge; locked_stable=1; retry_cnt=0.
2. Settle glitch: pll_lock drops for 1 cycle at settle count 5 -> returns to WAIT_LOCK; no retry; release occurs 8 synchronised cycles after lock returns.
3. Lock loss in RUN: pll_lock drops -> sys_rst=1 within 3 cycles of the drop; pll_resetb pulses low 4 cycles; retry_cnt=1; clean relock then gives retry_cnt=0.
4. Permanent no-lock: pll_lock held 0 -> 3 timeout attempts of 20 cycles each; then fault=1, state_o=5, sys_rst=1 (macro off); with PLL_BYPASS_FALLBACK_EN, pll_bypass=1 and sys_rst=0 after 4 cycles.
5. enable dropped mid-SETTLE, and in FAULT -> next edge state_o=0, pll_resetb=0, fault=0, retry_cnt=0.
6. Async rst asserted in RUN between clock edges -> sys_rst=1 and pll_resetb=0 immediately, before the next edge.
